// File: rtl/instr_pointer_stack_pkg.sv
// Shared definitions for the fetch-stage instruction pointer and the decoder.
//   IP_WORD_SIZE : default address/word width
//   ip_mode_e    : operation codes driven by the decoder on 'mode'
package instr_pointer_stack_pkg;

  localparam int IP_WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IP_MODE_ADJ  = 2'd0,
    IP_MODE_JUMP = 2'd1,
    IP_MODE_CALL = 2'd2,
    IP_MODE_RET  = 2'd3
  } ip_mode_e;

endpackage

// File: rtl/instr_pointer_stack_return_stack.sv
// Circular LIFO of return addresses.
// A push while full overwrites the oldest entry, and depth stays at STACK_DEPTH.
// The caller must not pop while the stack is empty.
// Ports:
//   clk, reset_enable   : clock, synchronous active-high reset (pointer/depth only)
//   push, push_data     : write push_data at top, advance top pointer
//   pop                 : retreat top pointer (caller guarantees not empty)
//   top_data            : entry below top pointer, 0 when empty
//   depth, full, empty  : occupancy
module instr_pointer_stack_return_stack #(
  parameter int WORD_SIZE   = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset_enable,
  input  logic                               push,
  input  logic                               pop,
  input  logic [WORD_SIZE-1:0]               push_data,
  output logic [WORD_SIZE-1:0]               top_data,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = $clog2(STACK_DEPTH+1);

  logic [WORD_SIZE-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]     top_ptr;
  logic [PTR_W-1:0]     ptr_inc;
  logic [PTR_W-1:0]     ptr_dec;

  // Explicit wrap so non-power-of-two depths also cycle correctly.
  assign ptr_inc = (top_ptr == PTR_W'(STACK_DEPTH-1)) ? '0 : top_ptr + PTR_W'(1);
  assign ptr_dec = (top_ptr == '0) ? PTR_W'(STACK_DEPTH-1) : top_ptr - PTR_W'(1);

  assign full     = (depth == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth == '0);
  assign top_data = empty ? '0 : mem[ptr_dec];

  always_ff @(posedge clk) begin
    if (reset_enable) begin
      top_ptr <= '0;
      depth   <= '0;
    end else if (push) begin
      top_ptr <= ptr_inc;
      if (!full) depth <= depth + DEPTH_W'(1);
    end else if (pop) begin
      top_ptr <= ptr_dec;
      depth   <= depth - DEPTH_W'(1);
    end
  end

  // Contents are deliberately not cleared on reset; empty masks them.
  always_ff @(posedge clk) begin
    if (!reset_enable && push) mem[top_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_pointer_stack.sv
// Fetch-stage instruction pointer with relative adjust, absolute jump,
// call and return, backed by a hardware return-address stack.
// Ports:
//   clk, reset_enable       : clock, synchronous active-high reset
//   update_enable, mode     : perform ADJ/JUMP/CALL/RET this cycle
//   adj, target             : signed offset (ADJ) / destination (JUMP, CALL)
//   clear_flags             : clears sticky overflow/underflow
//   out                     : registered instruction pointer
//   ret_top                 : peek of stack top (0 when empty)
//   depth, stack_full, stack_empty : stack occupancy
//   overflow, underflow     : sticky CALL-while-full / RET-while-empty
module instr_pointer_stack
  import instr_pointer_stack_pkg::*;
#(
  parameter int                   WORD_SIZE    = IP_WORD_SIZE,
  parameter int                   STACK_DEPTH  = 8,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
  parameter int                   RET_STEP     = 1
) (
  input  logic                             clk,
  input  logic                             reset_enable,
  input  logic                             update_enable,
  input  logic [1:0]                       mode,
  input  logic [WORD_SIZE-1:0]             adj,
  input  logic [WORD_SIZE-1:0]             target,
  input  logic                             clear_flags,
  output logic [WORD_SIZE-1:0]             out,
  output logic [WORD_SIZE-1:0]             ret_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             overflow,
  output logic                             underflow
);

  logic [WORD_SIZE-1:0] out_next;
  logic [WORD_SIZE-1:0] ret_addr;
  logic                 push;
  logic                 pop;
  logic                 set_ovf;
  logic                 set_udf;

  assign ret_addr = out + WORD_SIZE'(RET_STEP);

  always_comb begin
    out_next = out;
    push     = 1'b0;
    pop      = 1'b0;
    set_ovf  = 1'b0;
    set_udf  = 1'b0;
    if (update_enable) begin
      case (ip_mode_e'(mode))
        IP_MODE_ADJ:  out_next = out + adj;
        IP_MODE_JUMP: out_next = target;
        IP_MODE_CALL: begin
          push     = 1'b1;
          out_next = target;
          set_ovf  = stack_full;
        end
        IP_MODE_RET: begin
          if (stack_empty) begin
            set_udf = 1'b1;
          end else begin
            pop      = 1'b1;
            out_next = ret_top;
          end
        end
        default: out_next = out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_enable) begin
      out       <= RESET_VECTOR;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out       <= out_next;
      // A flag raised in the same cycle as clear_flags stays set.
      overflow  <= set_ovf | (overflow  & ~clear_flags);
      underflow <= set_udf | (underflow & ~clear_flags);
    end
  end

  instr_pointer_stack_return_stack #(
    .WORD_SIZE   (WORD_SIZE),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk          (clk),
    .reset_enable (reset_enable),
    .push         (push),
    .pop          (pop),
    .push_data    (ret_addr),
    .top_data     (ret_top),
    .depth        (depth),
    .full         (stack_full),
    .empty        (stack_empty)
  );

endmodule

// File: tb/tb_instr_pointer_stack.sv
module tb_instr_pointer_stack;
  import instr_pointer_stack_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_enable;
  logic         update_enable;
  logic [1:0]   mode;
  logic [W-1:0] adj;
  logic [W-1:0] target;
  logic         clear_flags;
  logic [W-1:0] out;
  logic [W-1:0] ret_top;
  logic [2:0]   depth;
  logic         stack_full;
  logic         stack_empty;
  logic         overflow;
  logic         underflow;

  int n_checks = 0;
  int n_pass   = 0;

  instr_pointer_stack #(
    .WORD_SIZE    (W),
    .STACK_DEPTH  (D),
    .RESET_VECTOR (16'h0100),
    .RET_STEP     (1)
  ) dut (
    .clk           (clk),
    .reset_enable  (reset_enable),
    .update_enable (update_enable),
    .mode          (mode),
    .adj           (adj),
    .target        (target),
    .clear_flags   (clear_flags),
    .out           (out),
    .ret_top       (ret_top),
    .depth         (depth),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at that point too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input ip_mode_e m, input logic [W-1:0] a, input logic [W-1:0] t);
    update_enable = 1'b1;
    mode          = m;
    adj           = a;
    target        = t;
    step();
    update_enable = 1'b0;
  endtask

  initial begin
    reset_enable  = 1'b1;
    update_enable = 1'b0;
    mode          = IP_MODE_ADJ;
    adj           = '0;
    target        = '0;
    clear_flags   = 1'b0;
    step();
    step();
    reset_enable = 1'b0;

    // 1. reset state and ADJ arithmetic
    check("rst_out", out, 16'h0100);
    check("rst_depth", depth, 0);
    check("rst_empty", stack_empty, 1);
    check("rst_full", stack_full, 0);
    check("rst_ret_top", ret_top, 0);
    check("rst_flags", {overflow, underflow}, 0);
    op(IP_MODE_ADJ, 16'd4, '0);    check("adj1", out, 16'h0104);
    op(IP_MODE_ADJ, 16'd4, '0);    check("adj2", out, 16'h0108);
    op(IP_MODE_ADJ, 16'd4, '0);    check("adj3", out, 16'h010C);
    op(IP_MODE_ADJ, 16'hFFFE, '0); check("adj_neg", out, 16'h010A);
    op(IP_MODE_JUMP, '0, 16'hFFFE); check("jump", out, 16'hFFFE);
    op(IP_MODE_ADJ, 16'd3, '0);    check("adj_wrap", out, 16'h0001);
    op(IP_MODE_ADJ, 16'hFFFF, '0); check("adj_wrap_down", out, 16'h0000);
    op(IP_MODE_ADJ, 16'd1, '0);    check("adj_back", out, 16'h0001);

    // 2. hold with update_enable low
    for (int i = 0; i < 5; i++) begin
      mode   = 2'(i);
      adj    = 16'($urandom);
      target = 16'($urandom);
      step();
      check("hold_out", out, 16'h0001);
      check("hold_depth", depth, 0);
      check("hold_ret_top", ret_top, 0);
    end

    // 3. nested call/return
    op(IP_MODE_JUMP, '0, 16'h0200);
    op(IP_MODE_CALL, '0, 16'h0300);
    check("call1_out", out, 16'h0300);
    check("call1_depth", depth, 1);
    check("call1_top", ret_top, 16'h0201);
    op(IP_MODE_CALL, '0, 16'h0400);
    check("call2_out", out, 16'h0400);
    check("call2_depth", depth, 2);
    check("call2_top", ret_top, 16'h0301);
    mode = IP_MODE_RET;
    step();
    check("hold_stack_depth", depth, 2);
    check("hold_stack_out", out, 16'h0400);
    op(IP_MODE_RET, '0, '0);
    check("ret1_out", out, 16'h0301);
    check("ret1_depth", depth, 1);
    check("ret1_top", ret_top, 16'h0201);
    op(IP_MODE_RET, '0, '0);
    check("ret2_out", out, 16'h0201);
    check("ret2_depth", depth, 0);
    check("ret2_empty", stack_empty, 1);

    // 4. overflow wraps over the oldest entry
    op(IP_MODE_JUMP, '0, 16'h0010);
    op(IP_MODE_CALL, '0, 16'h0020);
    op(IP_MODE_CALL, '0, 16'h0030);
    op(IP_MODE_CALL, '0, 16'h0040);
    check("fill3_full", stack_full, 0);
    op(IP_MODE_CALL, '0, 16'h0050);
    check("fill4_full", stack_full, 1);
    check("fill4_depth", depth, 4);
    check("fill4_ovf", overflow, 0);
    op(IP_MODE_CALL, '0, 16'h0060);
    check("ovf_flag", overflow, 1);
    check("ovf_depth", depth, 4);
    check("ovf_out", out, 16'h0060);
    check("ovf_top", ret_top, 16'h0051);
    op(IP_MODE_RET, '0, '0); check("pop_a", out, 16'h0051);
    op(IP_MODE_RET, '0, '0); check("pop_b", out, 16'h0041);
    op(IP_MODE_RET, '0, '0); check("pop_c", out, 16'h0031);
    op(IP_MODE_RET, '0, '0); check("pop_d", out, 16'h0021);
    check("drain_empty", stack_empty, 1);
    check("drain_top", ret_top, 0);
    check("ovf_sticky", overflow, 1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("ovf_clear", overflow, 0);

    // 5. underflow and clear priority
    op(IP_MODE_JUMP, '0, 16'h0123);
    op(IP_MODE_RET, '0, '0);
    check("udf_out", out, 16'h0123);
    check("udf_flag", underflow, 1);
    check("udf_depth", depth, 0);
    clear_flags = 1'b1;
    op(IP_MODE_RET, '0, '0);
    check("udf_set_wins", underflow, 1);
    step();
    clear_flags = 1'b0;
    check("udf_clear", underflow, 0);

    // 6. reset beats a concurrent CALL and discards history
    op(IP_MODE_CALL, '0, 16'h0500);
    op(IP_MODE_CALL, '0, 16'h0600);
    check("pre_rst_depth", depth, 2);
    reset_enable = 1'b1;
    op(IP_MODE_CALL, '0, 16'h0700);
    reset_enable = 1'b0;
    check("mid_rst_out", out, 16'h0100);
    check("mid_rst_depth", depth, 0);
    check("mid_rst_top", ret_top, 0);
    check("mid_rst_flags", {overflow, underflow}, 0);
    op(IP_MODE_RET, '0, '0);
    check("post_rst_udf", underflow, 1);
    check("post_rst_out", out, 16'h0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
